// File: rtl/param_memory_if.sv
// Request/response bundle for param_memory; requests are sampled every edge and results return one edge later.
// With MEM_PARITY_EN defined the bundle also carries par_inject (request side) and par_err (response side).
interface param_memory_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13
);
  logic              read_en;
  logic              write_en;
  logic [ADDR_W-1:0] in_address;
  logic [DATA_W-1:0] in_data;
  logic [DATA_W-1:0] out_dat_add;
  logic              rd_valid;
  logic              busy;
  logic              err_conflict;
  logic              err_range;
  logic              err_busy;
`ifdef MEM_PARITY_EN
  logic              par_inject;
  logic              par_err;
`endif

  modport master (
`ifdef MEM_PARITY_EN
    output par_inject,
    input  par_err,
`endif
    output read_en, write_en, in_address, in_data,
    input  out_dat_add, rd_valid, busy, err_conflict, err_range, err_busy
  );

  modport slave (
`ifdef MEM_PARITY_EN
    input  par_inject,
    output par_err,
`endif
    input  read_en, write_en, in_address, in_data,
    output out_dat_add, rd_valid, busy, err_conflict, err_range, err_busy
  );
endinterface

// File: rtl/param_memory.sv
// Single-port RAM with a reset-time init sweep (busy for DEPTH edges); 1-cycle read/write latency, no stalls in RUN.
// Requests during the sweep are dropped with err_busy. MEM_PARITY_EN adds a per-word even-parity bit.
module param_memory #(
  parameter int                DATA_W   = 18,
  parameter int                ADDR_W   = 13,
  parameter int                DEPTH    = 8192,
  parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  param_memory_if.slave bus
);

  if (DEPTH < 1 || DEPTH > (2 ** ADDR_W)) begin : g_bad_depth
    $error("param_memory: DEPTH must be within 1..2**ADDR_W");
  end

`ifdef MEM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
  localparam logic [MEM_W-1:0] INIT_WORD = {^INIT_VAL, INIT_VAL};
`else
  localparam int MEM_W = DATA_W;
  localparam logic [MEM_W-1:0] INIT_WORD = INIT_VAL;
`endif

  localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  logic [MEM_W-1:0] mem [DEPTH];

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] init_addr_q, init_addr_d;
  logic [DATA_W-1:0] out_dat_add_q, out_dat_add_d;
  logic              rd_valid_q, rd_valid_d;
  logic              busy_q, busy_d;
  logic              err_conflict_q, err_conflict_d;
  logic              err_range_q, err_range_d;
  logic              err_busy_q, err_busy_d;
  logic              par_err_q, par_err_d;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [MEM_W-1:0]  mem_wdata;
  logic [MEM_W-1:0]  rd_word;
  logic [MEM_W-1:0]  wr_word;
  logic              in_range;
  logic              any_req;

  assign in_range = ({1'b0, bus.in_address} < DEPTH_L);
  assign any_req  = bus.read_en | bus.write_en;
  assign rd_word  = mem[bus.in_address];

`ifdef MEM_PARITY_EN
  // Stored bit is even parity unless the client asks for a deliberately corrupted word.
  assign wr_word = {(^bus.in_data) ^ bus.par_inject, bus.in_data};
`else
  assign wr_word = bus.in_data;
`endif

  always_comb begin
    state_d        = state_q;
    init_addr_d    = init_addr_q;
    out_dat_add_d  = out_dat_add_q;
    rd_valid_d     = 1'b0;
    busy_d         = busy_q;
    err_conflict_d = 1'b0;
    err_range_d    = 1'b0;
    err_busy_d     = 1'b0;
    par_err_d      = 1'b0;
    mem_we         = 1'b0;
    mem_waddr      = init_addr_q;
    mem_wdata      = INIT_WORD;

    case (state_q)
      ST_INIT: begin
        mem_we      = 1'b1;
        init_addr_d = init_addr_q + 1'b1;
        err_busy_d  = any_req;
        if (init_addr_q == LAST_ADDR) begin
          state_d = ST_RUN;
          busy_d  = 1'b0;
        end
      end
      default: begin
        if (bus.read_en && bus.write_en) begin
          err_conflict_d = 1'b1;
        end else if (any_req && !in_range) begin
          // Out-of-range reads still complete, returning zero, so a reader never waits forever.
          err_range_d = 1'b1;
          if (bus.read_en) begin
            out_dat_add_d = '0;
            rd_valid_d    = 1'b1;
          end
        end else if (bus.read_en) begin
          out_dat_add_d = rd_word[DATA_W-1:0];
          rd_valid_d    = 1'b1;
          par_err_d     = ^rd_word;
        end else if (bus.write_en) begin
          mem_we    = 1'b1;
          mem_waddr = bus.in_address;
          mem_wdata = wr_word;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= ST_INIT;
      init_addr_q    <= '0;
      out_dat_add_q  <= '0;
      rd_valid_q     <= 1'b0;
      busy_q         <= 1'b1;
      err_conflict_q <= 1'b0;
      err_range_q    <= 1'b0;
      err_busy_q     <= 1'b0;
      par_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      init_addr_q    <= init_addr_d;
      out_dat_add_q  <= out_dat_add_d;
      rd_valid_q     <= rd_valid_d;
      busy_q         <= busy_d;
      err_conflict_q <= err_conflict_d;
      err_range_q    <= err_range_d;
      err_busy_q     <= err_busy_d;
      par_err_q      <= par_err_d;
    end
  end

  // Array has no reset: contents are only meaningful once the sweep has finished.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.out_dat_add  = out_dat_add_q;
  assign bus.rd_valid     = rd_valid_q;
  assign bus.busy         = busy_q;
  assign bus.err_conflict = err_conflict_q;
  assign bus.err_range    = err_range_q;
  assign bus.err_busy     = err_busy_q;
`ifdef MEM_PARITY_EN
  assign bus.par_err      = par_err_q;
`else
  logic unused_par;
  assign unused_par = par_err_q;
`endif

endmodule
